// File: rtl/peak_counter_pkg.sv
// Shared constants for the peak counter readout sequencer: command opcodes,
// header marker, FSM state type and a constant-foldable clog2 helper.
package peak_counter_pkg;

    localparam logic [1:0] OP_STOP    = 2'b00;
    localparam logic [1:0] OP_START   = 2'b01;
    localparam logic [1:0] OP_GET     = 2'b10;
    localparam logic [1:0] OP_GET_RST = 2'b11;

    // Marker byte in the upper half of the optional frame header word
    localparam logic [7:0] HDR_MARKER = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HDR,
        ST_SEND
    } state_t;

    // Ceiling log2; callers pass values >= 2
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/peak_counter_readout_seq_if.sv
// Command and host-transmit handshake bundle of the readout sequencer.
// slave: the sequencer side; master: the host/controller side.
interface peak_counter_readout_seq_if #(
    parameter int CNTR_WIDTH = 16
);
    logic                  cmd_vld_in;
    logic [1:0]            cmd_op_in;
    logic                  cmd_rdy_out;
    logic [CNTR_WIDTH-1:0] tx_data_out;
    logic                  tx_vld_out;
    logic                  tx_rdy_in;

    modport slave (
        input  cmd_vld_in, cmd_op_in, tx_rdy_in,
        output cmd_rdy_out, tx_data_out, tx_vld_out
    );

    modport master (
        output cmd_vld_in, cmd_op_in, tx_rdy_in,
        input  cmd_rdy_out, tx_data_out, tx_vld_out
    );
endinterface

// File: rtl/peak_counter_readout_seq.sv
// Peak counter readout sequencer: accepts STOP/START/GET/GET_RST commands,
// snapshots the datapath counters into the output shift register and streams
// CNTR_DEPTH words to the host FIFO under a valid/ready handshake.
// Optional frame header (marker + 8-bit frame sequence) is compiled in with
// the macro PEAK_READOUT_HEADER_EN.
module peak_counter_readout_seq
    import peak_counter_pkg::*;
#(
    parameter int CNTR_DEPTH = 24,
    parameter int CNTR_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    peak_counter_readout_seq_if.slave  bus,
    output logic                       counter_clk_en_out,
    output logic                       counter_clr_out,
    output logic                       sreg_load_en_out,
    output logic                       sreg_shift_en_out,
    input  logic [CNTR_WIDTH-1:0]      word_in,
    output logic                       running_out,
    output logic                       sending_out
);

    localparam int             CW       = clog2(CNTR_DEPTH + 1);
    localparam logic [CW-1:0]  LAST_IDX = CW'(CNTR_DEPTH - 1);

    state_t          state;
    state_t          state_nxt;
    logic            clr_flag;
    logic            run;
    logic [CW-1:0]   word_cnt;
    logic            cmd_acc;
    logic            word_acc;
    logic            last_word;
    logic [CNTR_WIDTH-1:0] tx_data;
    logic            tx_vld;

    // Commands only land in IDLE; anything offered elsewhere is dropped
    assign cmd_acc   = bus.cmd_vld_in & (state == ST_IDLE);
    assign word_acc  = (state == ST_SEND) & bus.tx_rdy_in;
    assign last_word = word_acc & (word_cnt == LAST_IDX);

`ifdef PEAK_READOUT_HEADER_EN
    logic [7:0] frame_seq;

    // Frame sequence number advances once per completed frame, wraps at 255
    always_ff @(posedge clk) begin
        if (rst)
            frame_seq <= 8'd0;
        else if (last_word)
            frame_seq <= frame_seq + 8'd1;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_acc && (bus.cmd_op_in == OP_GET || bus.cmd_op_in == OP_GET_RST))
                    state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
`ifdef PEAK_READOUT_HEADER_EN
                state_nxt = ST_HDR;
`else
                state_nxt = ST_SEND;
`endif
            end
            ST_HDR: begin
                if (bus.tx_rdy_in)
                    state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (last_word)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Run enable, clear flag and accepted-word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            run      <= 1'b1;
            clr_flag <= 1'b0;
            word_cnt <= '0;
        end else begin
            if (cmd_acc) begin
                case (bus.cmd_op_in)
                    OP_STOP:  run <= 1'b0;
                    OP_START: run <= 1'b1;
                    default: begin
                        // GET / GET_RST: counter enable left untouched
                        clr_flag <= (bus.cmd_op_in == OP_GET_RST);
                        word_cnt <= '0;
                    end
                endcase
            end else if (word_acc) begin
                word_cnt <= word_cnt + CW'(1);
            end
        end
    end

    // Output decode; data path is a straight pass-through of the shift head
    always_comb begin
        tx_data           = '0;
        tx_vld            = 1'b0;
        sreg_load_en_out  = 1'b0;
        counter_clr_out   = 1'b0;
        sreg_shift_en_out = 1'b0;
        case (state)
            ST_LOAD: begin
                sreg_load_en_out = 1'b1;
                counter_clr_out  = clr_flag;
            end
`ifdef PEAK_READOUT_HEADER_EN
            ST_HDR: begin
                tx_vld        = 1'b1;
                tx_data[15:0] = {HDR_MARKER, frame_seq};
            end
`endif
            ST_SEND: begin
                tx_vld            = 1'b1;
                tx_data           = word_in;
                sreg_shift_en_out = bus.tx_rdy_in;
            end
            default: ;
        endcase
    end

    assign bus.cmd_rdy_out  = (state == ST_IDLE);
    assign bus.tx_vld_out   = tx_vld;
    assign bus.tx_data_out  = tx_data;
    assign counter_clk_en_out = run;
    assign running_out        = run;
    assign sending_out        = (state == ST_HDR) | (state == ST_SEND);

endmodule
